// File: rtl/mem_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n_if
// Purpose : bundles the N requesting L1 pmem channels and the single L2 port
//           used by mem_arbiter_n.
// Signals : ch_read/ch_write/ch_address/ch_wdata  channel requests (flattened)
//           ch_rdata/ch_resp                      channel completion
//           l2_read/l2_write/l2_address/l2_wdata  downstream request
//           l2_resp/l2_rdata                      downstream completion
// Modports: slave  - the arbiter (accepts channel requests, drives L2)
//           master - the environment (channel clients plus L2 memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_n_if #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BLOCK_W = 256
);
  logic [NUM_CH-1:0]         ch_read;
  logic [NUM_CH-1:0]         ch_write;
  logic [NUM_CH*ADDR_W-1:0]  ch_address;
  logic [NUM_CH*BLOCK_W-1:0] ch_wdata;
  logic [BLOCK_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]         ch_resp;
  logic                      l2_read;
  logic                      l2_write;
  logic [ADDR_W-1:0]         l2_address;
  logic [BLOCK_W-1:0]        l2_wdata;
  logic                      l2_resp;
  logic [BLOCK_W-1:0]        l2_rdata;

  modport slave (
    input  ch_read, ch_write, ch_address, ch_wdata, l2_resp, l2_rdata,
    output ch_rdata, ch_resp, l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output ch_read, ch_write, ch_address, ch_wdata, l2_resp, l2_rdata,
    input  ch_rdata, ch_resp, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n
// Purpose : arbitrates N L1 pmem channels onto one L2 port. One transaction
//           outstanding; winner chosen round-robin, downstream request
//           registered, completion returned combinationally.
// Ports   : clk    - clock, all state on posedge
//           reset  - asynchronous, active-high
//           bus    - mem_arbiter_n_if.slave (channel and L2 signals)
// Config  : MEM_ARB_FIXED_PRIO_EN defined -> fixed priority, lowest index wins
//           (no round-robin pointer). Undefined -> round-robin.
// ---------------------------------------------------------------------------
module mem_arbiter_n #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BLOCK_W = 256
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_n_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [PTR_W-1:0]   r_grant;
  logic [PTR_W-1:0]   w_grant_nxt;
  logic               r_l2_read;
  logic               w_l2_read_nxt;
  logic               r_l2_write;
  logic               w_l2_write_nxt;
  logic [ADDR_W-1:0]  r_l2_address;
  logic [ADDR_W-1:0]  w_l2_address_nxt;
  logic [BLOCK_W-1:0] r_l2_wdata;
  logic [BLOCK_W-1:0] w_l2_wdata_nxt;

  logic [NUM_CH-1:0]  w_req;
  logic [PTR_W-1:0]   w_start;
  logic [SUM_W-1:0]   w_sum;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [BLOCK_W-1:0] w_sel_wdata;
  logic               w_sel_read;
  logic               w_sel_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Scan always starts at channel 0: lowest index wins.
  assign w_start = '0;
`else
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_ptr_nxt;
  logic [PTR_W-1:0]   w_grant_inc;

  assign w_start     = r_rr_ptr;
  // Channel after the current grant, wrapping NUM_CH-1 -> 0.
  assign w_grant_inc = (r_grant == PTR_W'(NUM_CH - 1)) ? '0 : r_grant + PTR_W'(1);
`endif

  assign w_req = bus.ch_read | bus.ch_write;

  // Winner: first requester scanning w_start, w_start+1, ... modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = SUM_W'(w_start) + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_CH)) begin
        w_sum = w_sum - SUM_W'(NUM_CH);
      end
      if (!w_found && w_req[w_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PTR_W-1:0];
      end
    end
  end

  // Payload of the winning channel; read+write together resolves to write.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_sel_addr  = bus.ch_address[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.ch_wdata[i*BLOCK_W +: BLOCK_W];
        w_sel_write = bus.ch_write[i];
        w_sel_read  = bus.ch_read[i] & ~bus.ch_write[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, pointer and downstream request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= '0;
      r_l2_read    <= 1'b0;
      r_l2_write   <= 1'b0;
      r_l2_address <= '0;
      r_l2_wdata   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rr_ptr     <= '0;
`endif
    end else begin
      r_grant      <= w_grant_nxt;
      r_l2_read    <= w_l2_read_nxt;
      r_l2_write   <= w_l2_write_nxt;
      r_l2_address <= w_l2_address_nxt;
      r_l2_wdata   <= w_l2_wdata_nxt;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rr_ptr     <= w_rr_ptr_nxt;
`endif
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_l2_read_nxt    = r_l2_read;
    w_l2_write_nxt   = r_l2_write;
    w_l2_address_nxt = r_l2_address;
    w_l2_wdata_nxt   = r_l2_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
    w_rr_ptr_nxt     = r_rr_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_BUSY;
          w_grant_nxt      = w_win;
          w_l2_read_nxt    = w_sel_read;
          w_l2_write_nxt   = w_sel_write;
          w_l2_address_nxt = w_sel_addr;
          w_l2_wdata_nxt   = w_sel_wdata;
        end
      end
      S_BUSY: begin
        // Address/wdata stay at the captured copy; only the strobes drop.
        if (bus.l2_resp) begin
          w_state_nxt    = S_IDLE;
          w_l2_read_nxt  = 1'b0;
          w_l2_write_nxt = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          w_rr_ptr_nxt   = w_grant_inc;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.l2_read    = r_l2_read;
  assign bus.l2_write   = r_l2_write;
  assign bus.l2_address = r_l2_address;
  assign bus.l2_wdata   = r_l2_wdata;
  assign bus.ch_rdata   = bus.l2_rdata;
  // Completion goes straight through to the granted channel only.
  assign bus.ch_resp    = (r_state == S_BUSY && bus.l2_resp) ? (NUM_CH'(1) << r_grant) : '0;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    ((bus.ch_read & bus.ch_write) == '0));
  a_resp_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.ch_resp));

endmodule

// File: tb/tb_mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_n
// Purpose : directed scoreboard bench for mem_arbiter_n with 4 channels.
//           Stimulus pushes expected completions; a monitor pops and compares
//           whenever ch_resp is presented.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_n;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned BW  = 256;

  logic clk;
  logic reset;

  mem_arbiter_n_if #(.NUM_CH(NCH), .ADDR_W(AW), .BLOCK_W(BW)) bus ();

  mem_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]   resp;
    logic [15:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] resp, input logic [15:0] addr, input logic wr,
                      input logic [255:0] wdata, input logic [255:0] rdata);
    exp_t e;
    e.resp  = resp;
    e.addr  = addr;
    e.rd    = ~wr;
    e.wr    = wr;
    e.wdata = wdata;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [15:0] a);
    bus.ch_address[ch*AW +: AW] = a;
  endtask

  // Returns at the first negedge where a downstream request is visible.
  task automatic wait_active(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.l2_read || bus.l2_write) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no l2 request within 20 cycles", name);
    end
  endtask

  // L2 memory model: answer the pending request after dly cycles, then
  // withdraw the channel requests in clr as the completion is consumed.
  task automatic respond(input int dly, input logic [255:0] data, input logic [3:0] clr);
    wait_active("respond");
    repeat (dly) tick();
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = data;
    tick();
    bus.l2_resp  = 1'b0;
    bus.ch_read  = bus.ch_read & ~clr;
    bus.ch_write = bus.ch_write & ~clr;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [255:0] dpat(input logic [31:0] tag);
    return {8{tag}};
  endfunction

  // Monitor: every presented completion must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.ch_resp != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got ch_resp=%b expected none", bus.ch_resp);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_ch_resp",  256'(bus.ch_resp),    256'(mon_e.resp));
        check("mon_ch_rdata", bus.ch_rdata,         mon_e.rdata);
        check("mon_l2_addr",  256'(bus.l2_address), 256'(mon_e.addr));
        check("mon_l2_read",  256'(bus.l2_read),    256'(mon_e.rd));
        check("mon_l2_write", 256'(bus.l2_write),   256'(mon_e.wr));
        check("mon_l2_wdata", bus.l2_wdata,         mon_e.wdata);
      end
    end
  end

  initial begin
    #100000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  logic [255:0] pat;

  initial begin
    reset          = 1'b1;
    bus.ch_read    = '0;
    bus.ch_write   = '0;
    bus.ch_address = '0;
    bus.ch_wdata   = '0;
    bus.l2_resp    = 1'b0;
    bus.l2_rdata   = '0;

    // Reset state
    @(negedge clk);
    check("rst_l2_read",  256'(bus.l2_read),    256'(0));
    check("rst_l2_write", 256'(bus.l2_write),   256'(0));
    check("rst_l2_addr",  256'(bus.l2_address), 256'(0));
    check("rst_l2_wdata", bus.l2_wdata,         256'(0));
    check("rst_ch_resp",  256'(bus.ch_resp),    256'(0));
    tick();
    reset = 1'b0;

    // 1. Single read on channel 0
    tick();
    push(4'b0001, 16'h1234, 1'b0, '0, {32{8'hA5}});
    set_addr(0, 16'h1234);
    bus.ch_read = 4'b0001;
    @(negedge clk);
    check("t1_read_latency", 256'(bus.l2_read), 256'(0));
    tick();
    check("t1_l2_read", 256'(bus.l2_read),    256'(1));
    check("t1_l2_addr", 256'(bus.l2_address), 256'(16'h1234));
    respond(2, {32{8'hA5}}, 4'b0001);
    @(negedge clk);
    check("t1_idle_read", 256'(bus.l2_read), 256'(0));

    // 2. Contention between channels 0 and 1, fresh pointer
    pulse_reset();
    set_addr(0, 16'h0100);
    set_addr(1, 16'h0200);
    set_addr(2, 16'h0300);
    set_addr(3, 16'h0400);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD200_0000 + k));
`else
    push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD200_0000));
    push(4'b0010, 16'h0200, 1'b0, '0, dpat(32'hD200_0001));
    push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD200_0002));
    push(4'b0010, 16'h0200, 1'b0, '0, dpat(32'hD200_0003));
`endif
    bus.ch_read = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      respond(2, dpat(32'hD200_0000 + k), (k == 3) ? 4'b0011 : 4'b0000);
    end

    // 3. Pointer wrap: ch2 moves pointer to 3, then ch3+ch0, then ch0+ch1
    push(4'b0100, 16'h0300, 1'b0, '0, dpat(32'hD300_0000));
    bus.ch_read = 4'b0100;
    respond(1, dpat(32'hD300_0000), 4'b0100);
    bus.ch_read = 4'b1001;
`ifdef MEM_ARB_FIXED_PRIO_EN
    push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD300_0001));
    push(4'b1000, 16'h0400, 1'b0, '0, dpat(32'hD300_0002));
    respond(1, dpat(32'hD300_0001), 4'b0001);
    respond(1, dpat(32'hD300_0002), 4'b1000);
`else
    push(4'b1000, 16'h0400, 1'b0, '0, dpat(32'hD300_0001));
    push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD300_0002));
    respond(1, dpat(32'hD300_0001), 4'b1000);
    respond(1, dpat(32'hD300_0002), 4'b0001);
`endif
    bus.ch_read = 4'b0011;
`ifdef MEM_ARB_FIXED_PRIO_EN
    push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD300_0003));
    push(4'b0010, 16'h0200, 1'b0, '0, dpat(32'hD300_0004));
    respond(1, dpat(32'hD300_0003), 4'b0001);
    respond(1, dpat(32'hD300_0004), 4'b0010);
`else
    push(4'b0010, 16'h0200, 1'b0, '0, dpat(32'hD300_0003));
    push(4'b0001, 16'h0100, 1'b0, '0, dpat(32'hD300_0004));
    respond(1, dpat(32'hD300_0003), 4'b0010);
    respond(1, dpat(32'hD300_0004), 4'b0001);
`endif

    // 4. Write on channel 1; payload changes during BUSY must not leak
    pat = {16{16'hC3A5}};
    set_addr(1, 16'h0040);
    bus.ch_wdata[1*BW +: BW] = pat;
    push(4'b0010, 16'h0040, 1'b1, pat, dpat(32'h0000_0000));
    bus.ch_write = 4'b0010;
    wait_active("t4");
    check("t4_l2_write", 256'(bus.l2_write), 256'(1));
    check("t4_l2_read",  256'(bus.l2_read),  256'(0));
    check("t4_wdata_0",  bus.l2_wdata,       pat);
    tick();
    bus.ch_wdata[1*BW +: BW] = ~pat;
    set_addr(1, 16'hFFFF);
    @(negedge clk);
    check("t4_wdata_held", bus.l2_wdata,         pat);
    check("t4_addr_held",  256'(bus.l2_address), 256'(16'h0040));
    respond(2, dpat(32'h0000_0000), 4'b0010);
    bus.ch_wdata = '0;

    // 5. Asynchronous reset in the middle of a transaction
    set_addr(1, 16'h0500);
    set_addr(3, 16'h0700);
    bus.ch_read = 4'b1010;
    wait_active("t5");
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("t5_pre_addr", 256'(bus.l2_address), 256'(16'h0500));
`else
    check("t5_pre_addr", 256'(bus.l2_address), 256'(16'h0700));
`endif
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_read",  256'(bus.l2_read),  256'(0));
    check("t5_rst_write", 256'(bus.l2_write), 256'(0));
    check("t5_rst_resp",  256'(bus.ch_resp),  256'(0));
    tick();
    push(4'b0010, 16'h0500, 1'b0, '0, dpat(32'hD500_0000));
    push(4'b1000, 16'h0700, 1'b0, '0, dpat(32'hD500_0001));
    reset = 1'b0;
    respond(1, dpat(32'hD500_0000), 4'b0010);
    respond(1, dpat(32'hD500_0001), 4'b1000);

    // 6. Spurious l2_resp while idle
    tick();
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = dpat(32'hDEAD_BEEF);
    @(negedge clk);
    check("t6_resp_idle", 256'(bus.ch_resp), 256'(0));
    tick();
    bus.l2_resp = 1'b0;
    @(negedge clk);
    check("t6_still_idle", 256'({bus.l2_read, bus.l2_write}), 256'(0));
    tick();
    set_addr(0, 16'h0ABC);
    push(4'b0001, 16'h0ABC, 1'b0, '0, dpat(32'hD600_0000));
    bus.ch_read = 4'b0001;
    respond(1, dpat(32'hD600_0000), 4'b0001);

    repeat (3) tick();
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
